// File: rtl/uwasic_onboarding_leozqi_if.sv
// Pin bundle for the UWASIC onboarding tile: the Tiny Tapeout user-project
// pins other than clock and reset, seen from the harness (master) and the design (slave).
interface uwasic_onboarding_leozqi_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/uwasic_onboarding_leozqi.sv
// UWASIC onboarding tile: a write-only SPI slave (mode 0, MSB first) loads five
// control registers that force each of 16 outputs low, high, or to a shared PWM.
module uwasic_onboarding_leozqi #(
    parameter int NUM_REGS = 5,
    parameter int PWM_DIV  = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uwasic_onboarding_leozqi_if.slave     bus
);

    localparam logic [6:0] ADDR_LIMIT = 7'(NUM_REGS);
    localparam logic [7:0] PRE_TC     = 8'(PWM_DIV);

    // Synchronizer and edge-history flops
    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_copi_meta, r_copi_sync;
    logic r_ncs_meta,  r_ncs_sync,  r_ncs_prev;

    // SPI receive state
    logic [15:0] r_shift;
    logic [4:0]  r_bit_cnt;

    // Control registers
    logic [15:0] r_en_out;
    logic [15:0] r_en_pwm;
    logic [7:0]  r_duty;

    // PWM timebase and output register
    logic [7:0]  r_prescale;
    logic [7:0]  r_pwm_cnt;
    logic [15:0] r_out;

    logic w_sclk_rise;
    logic w_ncs_fall;
    logic w_ncs_rise;
    logic w_commit;
    logic w_pwm_sig;
    logic w_unused;

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_ncs_fall  = ~r_ncs_sync & r_ncs_prev;
    assign w_ncs_rise  = r_ncs_sync & ~r_ncs_prev;

    // A frame is only accepted as a complete 16-bit write to an implemented register.
    assign w_commit = w_ncs_rise && (r_bit_cnt == 5'd16) && r_shift[15]
                      && (r_shift[14:8] < ADDR_LIMIT);

    // Full duty is special-cased so 0xFF is a true constant high.
    assign w_pwm_sig = (r_duty == 8'hFF) ? 1'b1 : (r_pwm_cnt < r_duty);

    // Pins the tile never looks at; folded together so they are visibly consumed.
    assign w_unused = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:3]};

    // Bring SCLK/COPI/nCS into the clk domain and keep one sample of history for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_copi_meta <= 1'b0;
            r_copi_sync <= 1'b0;
            r_ncs_meta  <= 1'b1;
            r_ncs_sync  <= 1'b1;
            r_ncs_prev  <= 1'b1;
        end else begin
            r_sclk_meta <= bus.ui_in[0];
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_copi_meta <= bus.ui_in[1];
            r_copi_sync <= r_copi_meta;
            r_ncs_meta  <= bus.ui_in[2];
            r_ncs_sync  <= r_ncs_meta;
            r_ncs_prev  <= r_ncs_sync;
        end
    end

    // Shift in COPI on SCLK rise while selected; the counter saturates at 17 to mark over-length frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= 16'h0000;
            r_bit_cnt <= 5'd0;
        end else if (w_ncs_fall) begin
            r_shift   <= 16'h0000;
            r_bit_cnt <= 5'd0;
        end else if (w_sclk_rise && !r_ncs_sync) begin
            if (r_bit_cnt < 5'd16) begin
                r_shift <= {r_shift[14:0], r_copi_sync};
            end else begin
                r_shift <= r_shift;
            end
            if (r_bit_cnt != 5'd17) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end else begin
            r_shift   <= r_shift;
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // Load the addressed control register when a valid frame closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out <= 16'h0000;
            r_en_pwm <= 16'h0000;
            r_duty   <= 8'h00;
        end else if (w_commit) begin
            case (r_shift[14:8])
                7'h00:   r_en_out[7:0]  <= r_shift[7:0];
                7'h01:   r_en_out[15:8] <= r_shift[7:0];
                7'h02:   r_en_pwm[7:0]  <= r_shift[7:0];
                7'h03:   r_en_pwm[15:8] <= r_shift[7:0];
                7'h04:   r_duty         <= r_shift[7:0];
                default: r_duty         <= r_duty;
            endcase
        end else begin
            r_duty <= r_duty;
        end
    end

    // Free-running PWM timebase: prescaler 0..PWM_DIV, counter steps on each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= 8'h00;
            r_pwm_cnt  <= 8'h00;
        end else if (r_prescale == PRE_TC) begin
            r_prescale <= 8'h00;
            r_pwm_cnt  <= r_pwm_cnt + 8'h01;
        end else begin
            r_prescale <= r_prescale + 8'h01;
            r_pwm_cnt  <= r_pwm_cnt;
        end
    end

    // Register the per-bit output select: disabled -> 0, enabled static -> 1, enabled PWM -> pwm_sig.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 16'h0000;
        end else begin
            r_out <= r_en_out & (~r_en_pwm | {16{w_pwm_sig}});
        end
    end

    assign bus.uo_out  = r_out[7:0];
    assign bus.uio_out = r_out[15:8];
    assign bus.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_leozqi.sv
// Directed bench for the UWASIC onboarding tile: SPI register writes, frame
// rejection, PWM timing, duty extremes, enable gating and mid-frame reset.
module tb_uwasic_onboarding_leozqi;

    logic clk;
    logic rst_n;
    logic sclk;
    logic copi;
    logic ncs;

    int n_vec;
    int n_err;

    uwasic_onboarding_leozqi_if bus ();

    assign bus.ena    = 1'b1;
    assign bus.uio_in = 8'h00;
    assign bus.ui_in  = {5'b00000, ncs, copi, sclk};

    uwasic_onboarding_leozqi dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 SPI: data set while SCLK low, sampled on rise; SCLK half period = 4 clk.
    task automatic spi_xfer(input logic [15:0] word, input int nbits);
        logic [15:0] sh;
        sh  = word;
        ncs = 1'b0;
        clks(4);
        for (int i = 0; i < nbits; i++) begin
            copi = sh[15];
            sh   = {sh[14:0], 1'b0};
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        copi = 1'b0;
        clks(4);
        ncs = 1'b1;
        clks(10);
    endtask

    task automatic wr(input logic [6:0] addr, input logic [7:0] data);
        spi_xfer({1'b1, addr, data}, 16);
    endtask

    // Advance until uo_out[0] equals lvl; cyc is the number of clocks advanced.
    task automatic wait_bit0(input logic lvl, output bit ok, output int cyc);
        cyc = 0;
        while ((bus.uo_out[0] !== lvl) && (cyc < 4000)) begin
            @(negedge clk);
            cyc++;
        end
        ok = (bus.uo_out[0] === lvl);
    endtask

    // Count clocks within a window where uo_out[0] differs from lvl.
    task automatic count_off(input logic lvl, input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.uo_out[0] !== lvl) bad++;
        end
    endtask

    initial begin
        bit ok;
        int cyc;
        int t_hi;
        int t_lo;
        int bad;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;

        // Reset state
        clks(5);
        chk("rst_uo_out", 32'(bus.uo_out), 32'h00);
        chk("rst_uio_out", 32'(bus.uio_out), 32'h00);
        chk("rst_uio_oe", 32'(bus.uio_oe), 32'hFF);
        rst_n = 1'b1;
        clks(5);

        // Static outputs
        wr(7'h00, 8'hF0);
        chk("static_uo_F0", 32'(bus.uo_out), 32'hF0);
        wr(7'h01, 8'hCC);
        chk("static_uio_CC", 32'(bus.uio_out), 32'hCC);
        wr(7'h00, 8'h00);
        chk("static_uo_00", 32'(bus.uo_out), 32'h00);
        wr(7'h01, 8'h00);
        chk("static_uio_00", 32'(bus.uio_out), 32'h00);

        // Rejected frames leave a preset 0x55 untouched
        wr(7'h00, 8'h55);
        chk("preset_55", 32'(bus.uo_out), 32'h55);
        spi_xfer(16'h00FF, 16);
        chk("reject_read", 32'(bus.uo_out), 32'h55);
        spi_xfer(16'hB0FF, 16);
        chk("reject_addr30", 32'(bus.uo_out), 32'h55);
        spi_xfer(16'h80FF, 15);
        chk("reject_15bit", 32'(bus.uo_out), 32'h55);
        spi_xfer(16'h80FF, 17);
        chk("reject_17bit", 32'(bus.uo_out), 32'h55);
        spi_xfer(16'h85FF, 16);
        chk("reject_addr05", 32'(bus.uo_out), 32'h55);

        // PWM 50 %: skip the possibly-truncated first pulse, then time a full period
        wr(7'h00, 8'h01);
        wr(7'h02, 8'h01);
        wr(7'h04, 8'h80);
        wait_bit0(1'b1, ok, cyc);
        chk("pwm_wait_rise0", 32'(ok), 32'd1);
        wait_bit0(1'b0, ok, cyc);
        chk("pwm_wait_fall0", 32'(ok), 32'd1);
        wait_bit0(1'b1, ok, cyc);
        chk("pwm_wait_rise1", 32'(ok), 32'd1);
        wait_bit0(1'b0, ok, t_hi);
        chk("pwm_wait_fall1", 32'(ok), 32'd1);
        wait_bit0(1'b1, ok, t_lo);
        chk("pwm_wait_rise2", 32'(ok), 32'd1);
        chk("pwm_high_time", 32'(t_hi), 32'd1664);
        chk("pwm_period", 32'(t_hi + t_lo), 32'd3328);

        // Duty extremes
        wr(7'h04, 8'h00);
        clks(4);
        count_off(1'b0, 6656, bad);
        chk("duty00_const0", 32'(bad), 32'd0);
        wr(7'h04, 8'hFF);
        clks(4);
        count_off(1'b1, 6656, bad);
        chk("dutyFF_const1", 32'(bad), 32'd0);

        // Enable gating
        wr(7'h04, 8'h80);
        wr(7'h00, 8'h00);
        clks(4);
        count_off(1'b0, 3328, bad);
        chk("gate_en_out_off", 32'(bad), 32'd0);
        wr(7'h00, 8'h01);
        wr(7'h02, 8'h00);
        clks(4);
        count_off(1'b1, 3328, bad);
        chk("gate_static_on", 32'(bad), 32'd0);
        chk("gate_uo_out", 32'(bus.uo_out), 32'h01);

        // Reset in the middle of a frame, then a clean frame after release
        ncs = 1'b0;
        clks(4);
        for (int i = 0; i < 8; i++) begin
            copi = 1'b1;
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        clks(5);
        chk("midrst_uo_out", 32'(bus.uo_out), 32'h00);
        ncs   = 1'b1;
        copi  = 1'b0;
        clks(2);
        rst_n = 1'b1;
        clks(5);
        chk("postrst_uo_out", 32'(bus.uo_out), 32'h00);
        wr(7'h00, 8'hA5);
        chk("postrst_write", 32'(bus.uo_out), 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
